// File: rtl/serial_frame_sync.sv
// Frame synchronizer: hunts for a serial sync word, then tracks frame timing
// (payload count + sync check), acquires lock after consecutive good syncs,
// flywheels through isolated sync errors and forwards payload bits while locked.
module serial_frame_sync #(
    parameter int unsigned          PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN     = 4'b1011,
    parameter int unsigned          PAYLOAD_LEN = 8,
    parameter int unsigned          LOCK_CNT    = 2,
    parameter int unsigned          MISS_CNT    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din_valid,
    input  logic din,
    output logic sync_pulse,
    output logic miss_err,
    output logic locked,
    output logic payload_valid,
    output logic payload_bit,
    output logic frame_start
);

    localparam int unsigned FILL_W = $clog2(PATTERN_W + 1);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned GM_W   = 4;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [PATTERN_W-1:0] window, window_d, shifted;
    logic [FILL_W-1:0]    fill, fill_d, fill_inc;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_d, bit_cnt_inc;
    logic [GM_W-1:0]      good, good_d, good_sat;
    logic [GM_W-1:0]      miss, miss_d, miss_inc;
    logic                 locked_d;
    logic                 sync_pulse_d, miss_err_d;
    logic                 payload_valid_d, payload_bit_d, frame_start_d;

    // Post-shift window and saturating/incremented counter values
    assign shifted     = {window[PATTERN_W-2:0], din};
    assign fill_inc    = (fill == FILL_W'(PATTERN_W)) ? fill : fill + FILL_W'(1);
    assign bit_cnt_inc = bit_cnt + CNT_W'(1);
    assign good_sat    = (good >= GM_W'(LOCK_CNT)) ? good : good + GM_W'(1);
    assign miss_inc    = miss + GM_W'(1);

    // Next-state, counter and output decode; only accepted bits change anything
    always_comb begin
        state_d         = state;
        window_d        = window;
        fill_d          = fill;
        bit_cnt_d       = bit_cnt;
        good_d          = good;
        miss_d          = miss;
        locked_d        = locked;
        sync_pulse_d    = 1'b0;
        miss_err_d      = 1'b0;
        payload_valid_d = 1'b0;
        payload_bit_d   = 1'b0;
        frame_start_d   = 1'b0;

        if (din_valid) begin
            window_d = shifted;
            case (state)
                HUNT: begin
                    fill_d = fill_inc;
                    if ((shifted == PATTERN) && (fill_inc == FILL_W'(PATTERN_W))) begin
                        sync_pulse_d = 1'b1;
                        good_d       = GM_W'(1);
                        miss_d       = '0;
                        bit_cnt_d    = '0;
                        state_d      = PAYLOAD;
                        if (LOCK_CNT == 1) begin
                            locked_d = 1'b1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (locked) begin
                        payload_valid_d = 1'b1;
                        payload_bit_d   = din;
                        frame_start_d   = (bit_cnt == '0);
                    end
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == CNT_W'(PAYLOAD_LEN)) begin
                        bit_cnt_d = '0;
                        state_d   = CHECK;
                    end
                end

                CHECK: begin
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == CNT_W'(PATTERN_W)) begin
                        bit_cnt_d = '0;
                        if (shifted == PATTERN) begin
                            sync_pulse_d = 1'b1;
                            good_d       = good_sat;
                            miss_d       = '0;
                            state_d      = PAYLOAD;
                            if (good_sat >= GM_W'(LOCK_CNT)) begin
                                locked_d = 1'b1;
                            end
                        end else begin
                            miss_err_d = 1'b1;
                            good_d     = '0;
                            if (!locked || (miss_inc >= GM_W'(MISS_CNT))) begin
                                // Drop back to a clean hunt
                                locked_d = 1'b0;
                                miss_d   = '0;
                                fill_d   = '0;
                                window_d = '0;
                                state_d  = HUNT;
                            end else begin
                                // Flywheel: keep lock and assume the frame boundary
                                miss_d  = miss_inc;
                                state_d = PAYLOAD;
                            end
                        end
                    end
                end

                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            window        <= '0;
            fill          <= '0;
            bit_cnt       <= '0;
            good          <= '0;
            miss          <= '0;
            locked        <= 1'b0;
            sync_pulse    <= 1'b0;
            miss_err      <= 1'b0;
            payload_valid <= 1'b0;
            payload_bit   <= 1'b0;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_d;
            window        <= window_d;
            fill          <= fill_d;
            bit_cnt       <= bit_cnt_d;
            good          <= good_d;
            miss          <= miss_d;
            locked        <= locked_d;
            sync_pulse    <= sync_pulse_d;
            miss_err      <= miss_err_d;
            payload_valid <= payload_valid_d;
            payload_bit   <= payload_bit_d;
            frame_start   <= frame_start_d;
        end
    end

endmodule
